// File: rtl/gcd_dispatch.sv
// Operand FIFO in front of a gcd core: issues pairs with a one-cycle start and returns results; zero operands bypass the core.
// Latency: push to start is 2 cycles, done to res_valid is 1 edge; in_ready low when full, results held until res_ready.
module gcd_dispatch #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     gcd_start,
    output logic [WIDTH-1:0]         gcd_a,
    output logic [WIDTH-1:0]         gcd_b,
    input  logic [WIDTH-1:0]         gcd_out,
    input  logic                     gcd_done,
    input  logic                     gcd_busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_gcd,
    output logic [WIDTH-1:0]         res_a,
    output logic [WIDTH-1:0]         res_b,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic [1:0]       state;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             head_vld;
    logic             head_az;
    logic             head_bz;
    logic             push;
    logic             pop;

    assign head_a   = mem_a[rd_ptr];
    assign head_b   = mem_b[rd_ptr];
    assign head_vld = (count != '0);
    assign head_az  = (head_a == '0);
    assign head_bz  = (head_b == '0);
    assign push     = in_valid && in_ready;
    // Zero-operand pairs never need the core, so they may leave even while it is busy.
    assign pop      = (state == S_IDLE) && head_vld && (head_az || head_bz || !gcd_busy);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            // Registered from the next count, so a same-cycle pop cannot open a full FIFO.
            in_ready <= (count_nxt < FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            gcd_start <= 1'b0;
            gcd_a     <= '0;
            gcd_b     <= '0;
            res_valid <= 1'b0;
            res_gcd   <= '0;
            res_a     <= '0;
            res_b     <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (head_vld) begin
                        if (head_az || head_bz) begin
                            res_gcd   <= head_a | head_b;
                            res_err   <= head_az && head_bz;
                            res_a     <= head_a;
                            res_b     <= head_b;
                            res_valid <= 1'b1;
                            state     <= S_HOLD;
                        end else if (!gcd_busy) begin
                            gcd_a     <= head_a;
                            gcd_b     <= head_b;
                            res_a     <= head_a;
                            res_b     <= head_b;
                            gcd_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    gcd_start <= 1'b0;
                    timer     <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (gcd_done) begin
                        res_gcd   <= gcd_out;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else if (timer == TLAST) begin
                        res_gcd   <= '0;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a behavioural gcd core (3-cycle latency, optional hang).
module tb_gcd_dispatch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       gcd_start;
    logic [3:0] gcd_a;
    logic [3:0] gcd_b;
    logic [3:0] gcd_out = '0;
    logic       gcd_done = 1'b0;
    logic       gcd_busy = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_gcd;
    logic [3:0] res_a;
    logic [3:0] res_b;
    logic       res_err;
    logic [2:0] count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    gcd_dispatch #(.WIDTH(4), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_out(gcd_out), .gcd_done(gcd_done), .gcd_busy(gcd_busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_gcd(res_gcd), .res_a(res_a), .res_b(res_b), .res_err(res_err),
        .count(count)
    );

    // Core model: computes on the start pulse, answers 3 cycles later; hang suppresses the answer.
    logic       hang = 1'b0;
    int         start_cnt = 0;
    int         core_cnt = 0;
    int         inj_req = 0;
    int         inj_ack = 0;
    logic [3:0] core_res = '0;

    function automatic logic [3:0] gcd_ref(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x = a;
        logic [3:0] y = b;
        logic [3:0] t;
        while (y != 4'd0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        gcd_done = 1'b0;
        if (gcd_start) start_cnt++;
        if (inj_req != inj_ack) begin
            inj_ack  = inj_req;
            gcd_done = 1'b1;
            gcd_out  = 4'd5;
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                gcd_done = 1'b1;
                gcd_out  = core_res;
                gcd_busy = 1'b0;
            end
        end else if (gcd_start && !hang) begin
            gcd_busy = 1'b1;
            core_cnt = 3;
            core_res = gcd_ref(gcd_a, gcd_b);
        end
    end

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] b;
        logic       e;
    } res_t;

    res_t rq[$];
    int   peak = 0;

    always @(negedge clk) begin
        if (res_valid && res_ready) rq.push_back({res_gcd, res_a, res_b, res_err});
        if (int'(count) > peak) peak = int'(count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_accept: in_ready stuck at %0b, wanted 1 within 200 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        int n = 0;
        while (rq.size() < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() < target) begin
            compared++;
            mismatched++;
            $display("FAIL result_wait: got %0d results, wanted %0d", rq.size(), target);
        end
        tick();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL rst_count: got %0d want 0", count); end
        compared++; if (gcd_start !== 1'b0) begin mismatched++; $display("FAIL rst_gcd_start: got %b want 0", gcd_start); end
        compared++; if ({res_gcd, res_a, res_b, res_err, gcd_a, gcd_b} !== 21'd0) begin
            mismatched++; $display("FAIL rst_data: got %h want 0", {res_gcd, res_a, res_b, res_err, gcd_a, gcd_b});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_release_early: got %b want 0", in_ready); end
        @(negedge clk);
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_single();
        int base = rq.size();
        int s0 = start_cnt;
        res_ready = 1'b1;
        push(4'd12, 4'd6);
        @(negedge clk);
        compared++; if (gcd_start !== 1'b0) begin mismatched++; $display("FAIL single_start_early: got %b want 0", gcd_start); end
        @(negedge clk);
        compared++; if (gcd_start !== 1'b1) begin mismatched++; $display("FAIL single_start_cycle: got %b want 1", gcd_start); end
        wait_res(base + 1);
        compared++; if (rq[base] !== {4'd6, 4'd12, 4'd6, 1'b0}) begin
            mismatched++; $display("FAIL single_result: got g=%0d a=%0d b=%0d e=%b want 6/12/6/0", rq[base].g, rq[base].a, rq[base].b, rq[base].e);
        end
        compared++; if (start_cnt - s0 != 1) begin mismatched++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [4] = '{4'd6, 4'd5, 4'd3, 4'd7};
        int base = rq.size();
        int s0 = start_cnt;
        res_ready = 1'b1;
        push(4'd12, 4'd6);
        push(4'd15, 4'd5);
        push(4'd9, 4'd3);
        push(4'd7, 4'd7);
        wait_res(base + 4);
        for (int i = 0; i < 4; i++) begin
            compared++; if (rq.size() > base + i && (rq[base+i].g !== exp_g[i] || rq[base+i].e !== 1'b0)) begin
                mismatched++; $display("FAIL b2b_result%0d: got %0d/%b want %0d/0", i, rq[base+i].g, rq[base+i].e, exp_g[i]);
            end
        end
        compared++; if (rq.size() > base + 1 && {rq[base+1].a, rq[base+1].b} !== {4'd15, 4'd5}) begin
            mismatched++; $display("FAIL b2b_operands: got %0d,%0d want 15,5", rq[base+1].a, rq[base+1].b);
        end
        compared++; if (start_cnt - s0 != 4) begin mismatched++; $display("FAIL b2b_starts: got %0d want 4", start_cnt - s0); end
        compared++; if (peak > 4) begin mismatched++; $display("FAIL b2b_peak: got %0d want <=4", peak); end
    endtask

    task automatic test_hold();
        logic [3:0] exp_g [5] = '{4'd6, 4'd5, 4'd3, 4'd7, 4'd4};
        int base = rq.size();
        res_ready = 1'b0;
        push(4'd12, 4'd6);
        push(4'd15, 4'd5);
        push(4'd9, 4'd3);
        push(4'd7, 4'd7);
        push(4'd12, 4'd8);
        repeat (12) @(negedge clk);
        compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL hold_count: got %0d want 4", count); end
        compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL hold_in_ready: got %b want 0", in_ready); end
        compared++; if ({res_valid, res_gcd, res_a, res_b, res_err} !== {1'b1, 4'd6, 4'd12, 4'd6, 1'b0}) begin
            mismatched++; $display("FAIL hold_result: got v=%b g=%0d a=%0d b=%0d want 1/6/12/6", res_valid, res_gcd, res_a, res_b);
        end
        repeat (6) @(negedge clk);
        compared++; if ({res_valid, res_gcd, res_a, res_b, res_err} !== {1'b1, 4'd6, 4'd12, 4'd6, 1'b0}) begin
            mismatched++; $display("FAIL hold_stable: got v=%b g=%0d a=%0d b=%0d want 1/6/12/6", res_valid, res_gcd, res_a, res_b);
        end
        tick();
        res_ready = 1'b1;
        wait_res(base + 5);
        for (int i = 0; i < 5; i++) begin
            compared++; if (rq.size() > base + i && rq[base+i].g !== exp_g[i]) begin
                mismatched++; $display("FAIL hold_drain%0d: got %0d want %0d", i, rq[base+i].g, exp_g[i]);
            end
        end
    endtask

    task automatic test_zero();
        int base = rq.size();
        int s0 = start_cnt;
        res_ready = 1'b1;
        push(4'd0, 4'd7);
        push(4'd9, 4'd0);
        push(4'd0, 4'd0);
        wait_res(base + 3);
        compared++; if (rq.size() > base && rq[base] !== {4'd7, 4'd0, 4'd7, 1'b0}) begin
            mismatched++; $display("FAIL zero_a: got g=%0d a=%0d b=%0d e=%b want 7/0/7/0", rq[base].g, rq[base].a, rq[base].b, rq[base].e);
        end
        compared++; if (rq.size() > base + 1 && {rq[base+1].g, rq[base+1].e} !== {4'd9, 1'b0}) begin
            mismatched++; $display("FAIL zero_b: got %0d/%b want 9/0", rq[base+1].g, rq[base+1].e);
        end
        compared++; if (rq.size() > base + 2 && {rq[base+2].g, rq[base+2].e} !== {4'd0, 1'b1}) begin
            mismatched++; $display("FAIL zero_both: got %0d/%b want 0/1", rq[base+2].g, rq[base+2].e);
        end
        compared++; if (start_cnt != s0) begin mismatched++; $display("FAIL zero_starts: got %0d want 0", start_cnt - s0); end
    endtask

    task automatic test_timeout();
        int base = rq.size();
        int s0;
        int n = 0;
        res_ready = 1'b1;
        hang = 1'b1;
        push(4'd8, 4'd4);
        while (!gcd_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++; if (gcd_start !== 1'b1) begin mismatched++; $display("FAIL to_start: got %b want 1", gcd_start); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 100);
        // 16 WAIT cycles, then res_valid on the following cycle.
        compared++; if (n != 17) begin mismatched++; $display("FAIL to_latency: got %0d cycles want 17", n); end
        wait_res(base + 1);
        compared++; if (rq.size() > base && rq[base] !== {4'd0, 4'd8, 4'd4, 1'b1}) begin
            mismatched++; $display("FAIL to_result: got g=%0d a=%0d b=%0d e=%b want 0/8/4/1", rq[base].g, rq[base].a, rq[base].b, rq[base].e);
        end
        hang = 1'b0;
        s0 = start_cnt;
        push(4'd9, 4'd6);
        wait_res(base + 2);
        compared++; if (rq.size() > base + 1 && {rq[base+1].g, rq[base+1].e} !== {4'd3, 1'b0}) begin
            mismatched++; $display("FAIL to_next: got %0d/%b want 3/0", rq[base+1].g, rq[base+1].e);
        end
        compared++; if (start_cnt - s0 != 1) begin mismatched++; $display("FAIL to_next_starts: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_reset_mid();
        int base;
        res_ready = 1'b1;
        hang = 1'b1;
        push(4'd15, 4'd5);
        push(4'd12, 4'd6);
        push(4'd7, 4'd7);
        repeat (3) @(negedge clk);
        compared++; if (count !== 3'd2) begin mismatched++; $display("FAIL mid_queued: got %0d want 2", count); end
        tick();
        rst_n = 1'b0;
        #1;
        compared++; if ({count, in_ready, res_valid, gcd_start, gcd_a, gcd_b, res_gcd} !== 18'd0) begin
            mismatched++; $display("FAIL mid_reset_outputs: got count=%0d rdy=%b v=%b st=%b a=%0d b=%0d want all 0", count, in_ready, res_valid, gcd_start, gcd_a, gcd_b);
        end
        tick();
        rst_n = 1'b1;
        hang = 1'b0;
        inj_req++;
        base = rq.size();
        repeat (10) @(negedge clk);
        compared++; if (rq.size() != base || res_valid !== 1'b0) begin
            mismatched++; $display("FAIL mid_late_done: got %0d results v=%b want 0/0", rq.size() - base, res_valid);
        end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL mid_count: got %0d want 0", count); end
        tick();
        push(4'd12, 4'd6);
        wait_res(base + 1);
        compared++; if (rq.size() > base && rq[base] !== {4'd6, 4'd12, 4'd6, 1'b0}) begin
            mismatched++; $display("FAIL mid_after: got g=%0d a=%0d b=%0d e=%b want 6/12/6/0", rq[base].g, rq[base].a, rq[base].b, rq[base].e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_zero();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
